// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-lite register read responder.
// Holds the AXI response codes and the read FSM state encoding.
package axil_pkg;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read FSM state encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/axil_reg_rd_resp.sv
// AXI4-lite read responder. Terminates AR/R from a bus master and drives a
// word-addressed register read port (en/wait/ack) into local logic.
// One read outstanding; out-of-range addresses get DECERR without a backend
// access, and a backend that neither acks nor asserts wait gets SLVERR.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   s_axil_ar*                 AXI read address channel (arprot ignored)
//   s_axil_r*                  AXI read data channel, held stable until rready
//   reg_rd_addr / reg_rd_en    word address and request, held through the access
//   reg_rd_wait                backend busy, freezes the timeout count
//   reg_rd_ack / reg_rd_data   completion strobe and read data
module axil_reg_rd_resp
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned STRB_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned DECODE_LIMIT = 0,
  parameter int unsigned TIMEOUT      = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [ADDR_WIDTH-1:0]                   s_axil_araddr,
  input  logic [2:0]                              s_axil_arprot,
  input  logic                                    s_axil_arvalid,
  output logic                                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]                   s_axil_rdata,
  output logic [1:0]                              s_axil_rresp,
  output logic                                    s_axil_rvalid,
  input  logic                                    s_axil_rready,
  output logic [ADDR_WIDTH-$clog2(STRB_WIDTH)-1:0] reg_rd_addr,
  output logic                                    reg_rd_en,
  input  logic                                    reg_rd_wait,
  input  logic                                    reg_rd_ack,
  input  logic [DATA_WIDTH-1:0]                   reg_rd_data
);

  localparam int unsigned AddrShift = $clog2(STRB_WIDTH);
  localparam int unsigned WordW     = ADDR_WIDTH - AddrShift;
  // Keep at least one bit so the counter stays legal when the timeout is disabled
  localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [1:0]            state_q,   state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q,  rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q,   rdata_d;
  logic [1:0]            rresp_q,   rresp_d;
  logic                  en_q,      en_d;
  logic [WordW-1:0]      addr_q,    addr_d;
  logic [CntW-1:0]       cnt_q,     cnt_d;

  logic dec_err;
  logic unused_arprot;

  assign unused_arprot = ^s_axil_arprot;

  // Full byte address compared before the low bits are dropped
  assign dec_err = (DECODE_LIMIT != 0) && (64'(s_axil_araddr) >= 64'(DECODE_LIMIT));

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    en_d      = en_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (s_axil_arvalid && arready_q) begin
          arready_d = 1'b0;
          addr_d    = s_axil_araddr[ADDR_WIDTH-1:AddrShift];
          if (dec_err) begin
            state_d  = ST_RESP;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_DECERR;
          end else begin
            state_d = ST_ACCESS;
            en_d    = 1'b1;
            cnt_d   = '0;
          end
        end
      end

      ST_ACCESS: begin
        // Ack takes priority over a timeout landing in the same cycle
        if (reg_rd_ack) begin
          state_d  = ST_RESP;
          en_d     = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = reg_rd_data;
          rresp_d  = RESP_OKAY;
        end else if ((TIMEOUT != 0) && !reg_rd_wait) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(TIMEOUT)) begin
            state_d  = ST_RESP;
            en_d     = 1'b0;
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
          end
        end
      end

      ST_RESP: begin
        if (s_axil_rready) begin
          state_d   = ST_IDLE;
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        en_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      en_q      <= 1'b0;
      addr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      en_q      <= en_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_rd_en      = en_q;
  assign reg_rd_addr    = addr_q;

endmodule

// File: tb/tb_axil_reg_rd_resp.sv
// Bench for axil_reg_rd_resp (DECODE_LIMIT=0x100, TIMEOUT=4). The driver
// scripts each read and, from the read rules, states what every output must
// be after each clock edge; a negedge process compares the DUT against that.
module tb_axil_reg_rd_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [13:0] rd_addr;
  logic        rd_en;
  logic        rd_wait;
  logic        rd_ack;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected outputs for the cycle following the most recent edge
  logic        exp_arready, exp_rvalid, exp_en, exp_full;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_rresp;
  logic [13:0] exp_addr;
  bit          cmp_en = 1'b0;

  axil_reg_rd_resp #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (16),
    .STRB_WIDTH  (4),
    .DECODE_LIMIT(32'h100),
    .TIMEOUT     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axil_araddr (araddr),
    .s_axil_arprot (arprot),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata  (rdata),
    .s_axil_rresp  (rresp),
    .s_axil_rvalid (rvalid),
    .s_axil_rready (rready),
    .reg_rd_addr   (rd_addr),
    .reg_rd_en     (rd_en),
    .reg_rd_wait   (rd_wait),
    .reg_rd_ack    (rd_ack),
    .reg_rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("arready", 32'(arready), 32'(exp_arready));
      check("rvalid", 32'(rvalid), 32'(exp_rvalid));
      check("reg_rd_en", 32'(rd_en), 32'(exp_en));
      if (exp_en || exp_full) check("reg_rd_addr", 32'(rd_addr), 32'(exp_addr));
      if (exp_rvalid || exp_full) begin
        check("rdata", rdata, exp_rdata);
        check("rresp", 32'(rresp), 32'(exp_rresp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    exp_arready = 1'b0;
    exp_rvalid  = 1'b0;
    exp_en      = 1'b0;
    exp_full    = 1'b1;
    exp_rdata   = '0;
    exp_rresp   = 2'b00;
    exp_addr    = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      arvalid = 1'b0;
      rd_ack  = 1'($urandom);
      rd_data = $urandom;
      rready  = 1'($urandom);
      step();
    end
    rd_ack = 1'b0;
  endtask

  // One read: wait_n cycles of wait, ack on access cycle ack_at (-1: never),
  // rready raised after rdelay RESP cycles. Returns what the DUT showed.
  task automatic do_read(input logic [15:0] addr, input logic [31:0] data, input int wait_n,
                         input int ack_at, input int rdelay, output logic [13:0] got_addr,
                         output logic [31:0] got_rdata, output logic [1:0] got_rresp,
                         output int got_en);
    int  cnt;
    int  i;
    bit  done;
    got_en   = 0;
    arvalid  = 1'b1;
    araddr   = addr;
    arprot   = 3'($urandom);
    rready   = 1'($urandom);
    rd_ack   = 1'b0;
    rd_wait  = 1'b0;
    step();
    arvalid     = 1'b0;
    exp_arready = 1'b0;
    exp_full    = 1'b0;
    exp_addr    = addr[15:2];
    got_addr    = rd_addr;
    if (addr >= 16'h0100) begin
      exp_rvalid = 1'b1;
      exp_rdata  = '0;
      exp_rresp  = 2'b11;
    end else begin
      exp_en = 1'b1;
      cnt    = 0;
      i      = 0;
      done   = 1'b0;
      while (!done) begin
        if (rd_en) got_en++;
        rd_wait = (i < wait_n);
        rd_ack  = (i == ack_at);
        rd_data = rd_ack ? data : $urandom;
        arvalid = 1'($urandom);
        araddr  = 16'($urandom);
        rready  = 1'($urandom);
        step();
        if (rd_ack) begin
          exp_en = 1'b0; exp_rvalid = 1'b1; exp_rdata = data; exp_rresp = 2'b00; done = 1'b1;
        end else if (!rd_wait) begin
          cnt++;
          if (cnt == 4) begin
            exp_en = 1'b0; exp_rvalid = 1'b1; exp_rdata = '0; exp_rresp = 2'b10; done = 1'b1;
          end
        end
        i++;
      end
      rd_wait = 1'b0;
    end
    got_rdata = rdata;
    got_rresp = rresp;
    for (int k = 0; k <= rdelay; k++) begin
      rready  = (k == rdelay);
      arvalid = (k == rdelay) ? 1'b0 : 1'($urandom);
      araddr  = 16'($urandom);
      rd_ack  = 1'($urandom);
      rd_data = $urandom;
      step();
    end
    exp_rvalid  = 1'b0;
    exp_arready = 1'b1;
    arvalid     = 1'b0;
    rready      = 1'($urandom);
    rd_ack      = 1'b0;
  endtask

  logic [13:0] g_addr;
  logic [31:0] g_rdata;
  logic [1:0]  g_rresp;
  int          g_en;

  initial begin
    rst_n   = 1'b0;
    araddr  = '0;
    arprot  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    rd_wait = 1'b0;
    rd_ack  = 1'b0;
    rd_data = '0;
    set_reset_exp();
    cmp_en = 1'b1;
    #2;
    check("reset_arready", 32'(arready), 32'd0);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_arready = 1'b1;
    check("arready_after_release", 32'(arready), 32'd1);

    // Stray ack/rready while idle must not produce a response
    idle(4);

    // Normal read, ack two cycles after en rises
    do_read(16'h0010, 32'hDEADBEEF, 0, 2, 0, g_addr, g_rdata, g_rresp, g_en);
    check("t1_addr", 32'(g_addr), 32'h004);
    check("t1_rdata", g_rdata, 32'hDEADBEEF);
    check("t1_rresp", 32'(g_rresp), 32'd0);
    check("t1_en_cycles", 32'(g_en), 32'd3);

    // Decode error: no backend access
    do_read(16'h0104, 32'h0, 0, -1, 0, g_addr, g_rdata, g_rresp, g_en);
    check("t2_rresp", 32'(g_rresp), 32'd3);
    check("t2_rdata", g_rdata, 32'd0);
    check("t2_en_cycles", 32'(g_en), 32'd0);

    // Timeout with wait low
    do_read(16'h0040, 32'h0, 0, -1, 0, g_addr, g_rdata, g_rresp, g_en);
    check("t3_rresp", 32'(g_rresp), 32'd2);
    check("t3_rdata", g_rdata, 32'd0);
    check("t3_en_cycles", 32'(g_en), 32'd4);

    // Long wait then ack
    do_read(16'h0044, 32'h12345678, 10, 10, 1, g_addr, g_rdata, g_rresp, g_en);
    check("t3b_rresp", 32'(g_rresp), 32'd0);
    check("t3b_rdata", g_rdata, 32'h12345678);
    check("t3b_en_cycles", 32'(g_en), 32'd11);

    // Back-pressure in RESP, then back-to-back read
    do_read(16'h0008, 32'hA5A50F0F, 1, 1, 5, g_addr, g_rdata, g_rresp, g_en);
    check("t4_rdata", g_rdata, 32'hA5A50F0F);

    // Ack on the cycle the timeout would fire
    do_read(16'h000C, 32'hCAFEF00D, 0, 3, 0, g_addr, g_rdata, g_rresp, g_en);
    check("t5_rresp", 32'(g_rresp), 32'd0);
    check("t5_rdata", g_rdata, 32'hCAFEF00D);
    check("t5_en_cycles", 32'(g_en), 32'd4);
    idle(3);

    // Reset in the middle of an access
    arvalid = 1'b1;
    araddr  = 16'h0020;
    step();
    arvalid     = 1'b0;
    exp_arready = 1'b0;
    exp_en      = 1'b1;
    exp_addr    = 14'h008;
    exp_full    = 1'b0;
    rd_wait     = 1'b1;
    step();
    rst_n = 1'b0;
    set_reset_exp();
    #1;
    check("t6_en_async", 32'(rd_en), 32'd0);
    check("t6_rvalid_async", 32'(rvalid), 32'd0);
    check("t6_arready_async", 32'(arready), 32'd0);
    rd_wait = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    exp_arready = 1'b1;
    check("t6_arready_release", 32'(arready), 32'd1);
    do_read(16'h0030, 32'h0BADF00D, 0, 1, 0, g_addr, g_rdata, g_rresp, g_en);
    check("t6_next_rdata", g_rdata, 32'h0BADF00D);
    check("t6_next_rresp", 32'(g_rresp), 32'd0);

    // Randomized reads
    for (int t = 0; t < 300; t++) begin
      do_read(16'($urandom_range(0, 16'h1ff)), $urandom, int'($urandom_range(0, 4)),
              ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 6)),
              int'($urandom_range(0, 3)), g_addr, g_rdata, g_rresp, g_en);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    step();
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
